// File: rtl/forward_pipe_pkg.sv
// ============================================================================
// forward_pipe_pkg : shared constants and helpers for the forward register slice
// Revision: 1.0
// ============================================================================
`default_nettype none

package forward_pipe_pkg;

    localparam int c_DEFAULT_L = 8;

    // Bits needed to hold values 0..n-1; used to size the occupancy counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/forward_pipe_stage.sv
// ============================================================================
// forward_stage : one valid+data register of the forward pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module forward_stage
    import forward_pipe_pkg::*;
#(
    parameter int L = c_DEFAULT_L
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         i_en,
    input  logic         i_valid,
    input  logic [L-1:0] i_data,
    output logic         o_valid,
    output logic [L-1:0] o_data
);

    logic         r_valid;
    logic [L-1:0] r_data;

    // Data only loads on a real beat, so an emptied stage keeps its last payload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (i_en) begin
                r_valid <= i_valid;
            end
            if (i_en && i_valid && !flush) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/forward_pipe.sv
// ============================================================================
// forward_pipe : DEPTH-stage bubble-collapsing forward register slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module forward_pipe
    import forward_pipe_pkg::*;
#(
    parameter int L     = c_DEFAULT_L,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    output logic                        ready_f,
    input  logic                        valid_f,
    input  logic [L-1:0]                data_f,
    input  logic                        ready_b,
    output logic                        valid_b,
    output logic [L-1:0]                data_b,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int c_CW = clog2(DEPTH + 1);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("forward_pipe: DEPTH must be at least 1");
        end
    endgenerate

    logic [DEPTH:0]   w_en;
    logic [DEPTH-1:0] w_v;
    logic [L-1:0]     w_d [DEPTH];
    logic             w_xfer_in;
    logic             w_xfer_out;
    logic [c_CW-1:0]  r_count;

    // A stage may move when it is empty or everything downstream of it moves.
    assign w_en[DEPTH] = ready_b;

    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            logic         w_in_v;
            logic [L-1:0] w_in_d;

            if (s == 0) begin : g_first
                assign w_in_v = valid_f;
                assign w_in_d = data_f;
            end else begin : g_rest
                assign w_in_v = w_v[s-1];
                assign w_in_d = w_d[s-1];
            end

            assign w_en[s] = !w_v[s] || w_en[s+1];

            forward_stage #(
                .L(L)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .i_en    (w_en[s]),
                .i_valid (w_in_v),
                .i_data  (w_in_d),
                .o_valid (w_v[s]),
                .o_data  (w_d[s])
            );
        end
    endgenerate

    assign ready_f    = rst && !flush && w_en[0];
    assign valid_b    = w_v[DEPTH-1];
    assign data_b     = w_d[DEPTH-1];
    assign w_xfer_in  = valid_f && ready_f;
    assign w_xfer_out = valid_b && ready_b;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_count <= '0;
        end else if (w_xfer_in && !w_xfer_out) begin
            r_count <= r_count + c_CW'(1);
        end else if (!w_xfer_in && w_xfer_out) begin
            r_count <= r_count - c_CW'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_forward_pipe.sv
// ============================================================================
// tb_forward_pipe : directed and random checks of forward_pipe at DEPTH 1, 2 and 4
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_forward_pipe;

    logic       clk = 1'b0;
    logic       rst, flush, valid_f, ready_b;
    logic [7:0] data_f;

    logic       rf1, rf2, rf4, vb1, vb2, vb4;
    logic [7:0] db1, db2, db4;
    logic [0:0] c1;
    logic [1:0] c2;
    logic [2:0] c4;

    always #5 clk = ~clk;

    forward_pipe #(.L(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush), .ready_f(rf1), .valid_f(valid_f),
        .data_f(data_f), .ready_b(ready_b), .valid_b(vb1), .data_b(db1), .count(c1));
    forward_pipe #(.L(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .ready_f(rf2), .valid_f(valid_f),
        .data_f(data_f), .ready_b(ready_b), .valid_b(vb2), .data_b(db2), .count(c2));
    forward_pipe #(.L(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush), .ready_f(rf4), .valid_f(valid_f),
        .data_f(data_f), .ready_b(ready_b), .valid_b(vb4), .data_b(db4), .count(c4));

    logic       rf [3];
    logic       vb [3];
    logic [7:0] db [3];
    logic [2:0] cn [3];
    int         dep [3] = '{1, 2, 4};

    assign rf[0] = rf1;  assign rf[1] = rf2;  assign rf[2] = rf4;
    assign vb[0] = vb1;  assign vb[1] = vb2;  assign vb[2] = vb4;
    assign db[0] = db1;  assign db[1] = db2;  assign db[2] = db4;
    assign cn[0] = {2'b00, c1};
    assign cn[1] = {1'b0, c2};
    assign cn[2] = c4;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q [3][$];
    logic       st_hold [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] st_data [3];
    logic [7:0] m_exp;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; everything is sampled 1 unit before the rising edge.
    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic rb, input logic fl);
        @(negedge clk);
        rst     = r;
        valid_f = v;
        data_f  = d;
        ready_b = rb;
        flush   = fl;
        #4;
    endtask

    // Scoreboard monitor: model occupancy is the queue length of accepted-but-undelivered beats.
    always begin
        @(negedge clk);
        #4;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                q[k].delete();
                st_hold[k] = 1'b0;
            end else begin
                chk($sformatf("d%0d_count", dep[k]), int'(cn[k]), q[k].size());
                chk($sformatf("d%0d_ready_f", dep[k]), int'(rf[k]),
                    int'(!flush && (q[k].size() < dep[k] || ready_b)));
                if (st_hold[k]) begin
                    chk($sformatf("d%0d_stall_valid", dep[k]), int'(vb[k]), 1);
                    chk($sformatf("d%0d_stall_data", dep[k]), int'(db[k]), int'(st_data[k]));
                end
                if (vb[k] && ready_b) begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("d%0d_unexpected_beat", dep[k]), int'(db[k]), -1);
                    end else begin
                        m_exp = q[k].pop_front();
                        chk($sformatf("d%0d_data_out", dep[k]), int'(db[k]), int'(m_exp));
                    end
                end
                if (flush) begin
                    q[k].delete();
                end else if (valid_f && rf[k]) begin
                    q[k].push_back(data_f);
                end
                st_hold[k] = vb[k] && !ready_b && !flush;
                st_data[k] = db[k];
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; valid_f = 1'b1; ready_b = 1'b0; data_f = 8'hEE;

        // Reset with valid_f held high
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
            chk("rst_ready_f", int'(rf2), 0);
            if (i >= 1) begin
                chk("rst_valid_b", int'(vb2), 0);
                chk("rst_data_b", int'(db2), 0);
                chk("rst_count", int'(c2), 0);
            end
        end
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_ready_f", int'(rf2), 1);

        // Back-to-back stream 0x01..0x10, two-cycle latency, no gaps
        for (int c = 0; c < 18; c++) begin
            drive(1'b1, c < 16, 8'(c + 1), 1'b1, 1'b0);
            if (c < 16) chk("stream_ready_f", int'(rf2), 1);
            if (c >= 2) begin
                chk("stream_valid_b", int'(vb2), 1);
                chk("stream_data_b", int'(db2), c - 1);
            end else begin
                chk("stream_lat_valid_b", int'(vb2), 0);
            end
        end
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_drained", int'(vb2), 0);

        // Backpressure with full pipe, then simultaneous in/out
        drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("bp_count", int'(c2), 2);
        chk("bp_ready_f", int'(rf2), 0);
        chk("bp_data_b", int'(db2), 8'hA5);
        drive(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("bp_hold_ready_f", int'(rf2), 0);
        drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
        chk("bp_release_ready_f", int'(rf2), 1);
        chk("bp_out0", int'(db2), 8'hA5);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_out1", int'(db2), 8'h5A);
        chk("bp_full_count", int'(c2), 2);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_out2", int'(db2), 8'h3C);
        chk("bp_count_1", int'(c2), 1);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_empty", int'(vb2), 0);

        // Bubble collapse under stall
        drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        chk("bub_ready_f", int'(rf2), 1);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("bub_count", int'(c2), 2);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bub_out0", int'(db2), 8'h11);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bub_out1_valid", int'(vb2), 1);
        chk("bub_out1", int'(db2), 8'h22);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bub_empty", int'(vb2), 0);

        // Flush with a beat offered in the flush cycle
        drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        chk("flush_ready_f", int'(rf2), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            chk("flush_count", int'(c2), 0);
            chk("flush_valid_b", int'(vb2), 0);
            chk("flush_data_hold", int'(db2), 8'h44);
        end

        // Random traffic on all three depths, occasional flush
        for (int i = 0; i < 8000; i++) begin
            drive(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(63) == 0));
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("d1_drained", int'(c1), 0);
        chk("d2_drained", int'(c2), 0);
        chk("d4_drained", int'(c4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
